// File: rtl/regfile_wb_sched.sv
// Write-back scheduler and load scoreboard for the register file write port.
// Optional macro REGFILE_WB_SCOREBOARD_EN builds the busy scoreboard; otherwise busy=0 and issue_ready=1.
module regfile_wb_sched #(
    parameter int STARVE_LIM = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        issue_ready,
    input  logic [4:0]  chk_rs1,
    input  logic [4:0]  chk_rs2,
    output logic        hazard,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    input  logic        dbg_valid,
    output logic        dbg_ready,
    input  logic [4:0]  dbg_rd,
    input  logic [31:0] dbg_data,
    output logic        rf_w_en,
    output logic [4:0]  rf_w_sel,
    output logic [31:0] rf_w_data,
    output logic [31:0] busy
);

    localparam logic [7:0] LIM = 8'(STARVE_LIM);

    logic [7:0]  starve_cnt;
    logic        starved;
    logic        alu_xfer, lsu_xfer, dbg_xfer, any_xfer;
    logic [4:0]  win_rd;
    logic [31:0] win_data;
    logic        inflight_hit;

    // Handshake: a transfer happens on a rising edge with X_valid && X_ready.
    // Readies depend only on the valids and the starvation state, and at most one is high.
    assign starved = (starve_cnt == LIM);

    always_comb begin
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        dbg_ready = 1'b0;
        if (starved && dbg_valid) begin
            dbg_ready = 1'b1;
        end else if (lsu_valid) begin
            lsu_ready = 1'b1;
        end else if (alu_valid) begin
            alu_ready = 1'b1;
        end else if (dbg_valid) begin
            dbg_ready = 1'b1;
        end
    end

    assign alu_xfer = alu_valid && alu_ready;
    assign lsu_xfer = lsu_valid && lsu_ready;
    assign dbg_xfer = dbg_valid && dbg_ready;
    assign any_xfer = alu_xfer || lsu_xfer || dbg_xfer;

    always_comb begin
        win_rd   = dbg_rd;
        win_data = dbg_data;
        if (lsu_xfer) begin
            win_rd   = lsu_rd;
            win_data = lsu_data;
        end else if (alu_xfer) begin
            win_rd   = alu_rd;
            win_data = alu_data;
        end
    end

    // Counts cycles debug has been refused; holds at the limit until granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!dbg_valid || dbg_xfer) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_w_en   <= 1'b0;
            rf_w_sel  <= '0;
            rf_w_data <= '0;
        end else begin
            rf_w_en <= any_xfer && (win_rd != 5'd0);
            if (any_xfer) begin
                rf_w_sel  <= win_rd;
                rf_w_data <= win_data;
            end
        end
    end

    // The just-registered write is not yet readable from the regfile.
    assign inflight_hit = rf_w_en &&
                          (((chk_rs1 != 5'd0) && (chk_rs1 == rf_w_sel)) ||
                           ((chk_rs2 != 5'd0) && (chk_rs2 == rf_w_sel)));

`ifdef REGFILE_WB_SCOREBOARD_EN
    logic [31:0] busy_q;
    logic [31:0] busy_next;
    logic        issue_xfer;
    logic        busy_hit;

    // Bit 0 can never be set, so x0 is always issue-ready.
    assign issue_ready = !busy_q[issue_rd];
    assign issue_xfer  = issue_valid && issue_ready;

    always_comb begin
        busy_next = busy_q;
        if (lsu_xfer) begin
            busy_next[lsu_rd] = 1'b0;
        end
        if (issue_xfer && (issue_rd != 5'd0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign busy_hit = ((chk_rs1 != 5'd0) && busy_q[chk_rs1]) ||
                      ((chk_rs2 != 5'd0) && busy_q[chk_rs2]);
    assign busy     = busy_q;
    assign hazard   = busy_hit || inflight_hit;
`else
    logic unused_issue;

    assign unused_issue = ^{issue_valid, issue_rd};
    assign issue_ready  = 1'b1;
    assign busy         = '0;
    assign hazard       = inflight_hit;
`endif

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: arbitration table plus reset, starvation,
// x0 and scoreboard sequences (scoreboard part follows REGFILE_WB_SCOREBOARD_EN).
module tb_regfile_wb_sched;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        hazard;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        dbg_valid, dbg_ready;
    logic [4:0]  dbg_rd;
    logic [31:0] dbg_data;
    logic        rf_w_en;
    logic [4:0]  rf_w_sel;
    logic [31:0] rf_w_data;
    logic [31:0] busy;

    int n_vec;
    int n_err;

    regfile_wb_sched #(.STARVE_LIM(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard(hazard),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_rd(dbg_rd), .dbg_data(dbg_data),
        .rf_w_en(rf_w_en), .rf_w_sel(rf_w_sel), .rf_w_data(rf_w_data), .busy(busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        dv;
        logic [4:0]  drd;
        logic [31:0] dd;
        logic [2:0]  exp_rdy;   // {lsu, alu, dbg}
        logic        exp_en;
        logic [4:0]  exp_sel;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive_idle();
        issue_valid = 1'b0; issue_rd = 5'd0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
        dbg_valid = 1'b0; dbg_rd = 5'd0; dbg_data = 32'd0;
        chk_rs1 = 5'd0; chk_rs2 = 5'd0;
    endtask

    task automatic drive_vec(input vec_t v);
        lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ld;
        alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
        dbg_valid = v.dv; dbg_rd = v.drd; dbg_data = v.dd;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    int grant_cyc;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive_idle();

        //               lsu                  alu                 dbg                rdy     en    sel    data
        vecs[0] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h1234, 1'b0, 5'd0,  32'h0,  3'b010, 1'b1, 5'd3,  32'h1234};
        vecs[1] = '{1'b1, 5'd6, 32'hB,        1'b1, 5'd4, 32'hA,    1'b0, 5'd0,  32'h0,  3'b100, 1'b1, 5'd6,  32'hB};
        vecs[2] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 32'hA,    1'b0, 5'd0,  32'h0,  3'b010, 1'b1, 5'd4,  32'hA};
        vecs[3] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd7,  32'h77, 3'b001, 1'b1, 5'd7,  32'h77};
        vecs[4] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'h55,   1'b1, 5'd8,  32'h88, 3'b010, 1'b1, 5'd5,  32'h55};
        vecs[5] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,  3'b000, 1'b0, 5'd5,  32'h55};
        vecs[6] = '{1'b1, 5'd1, 32'hFFFFFFFF, 1'b1, 5'd2, 32'h22,   1'b1, 5'd8,  32'h88, 3'b100, 1'b1, 5'd1,  32'hFFFFFFFF};
        vecs[7] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd31, 32'h31, 3'b001, 1'b1, 5'd31, 32'h31};

        // reset state
        @(negedge clk);
        #1;
        check("reset_w_en", 32'(rf_w_en), 32'd0);
        check("reset_w_sel", 32'(rf_w_sel), 32'd0);
        check("reset_w_data", rf_w_data, 32'd0);
        check("reset_busy", busy, 32'd0);
        check("reset_readies", 32'({lsu_ready, alu_ready, dbg_ready}), 32'd0);
        check("reset_issue_ready", 32'(issue_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // arbitration table, one vector per cycle
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive_vec(vecs[i]);
            #1;
            check($sformatf("v%0d_ready", i), 32'({lsu_ready, alu_ready, dbg_ready}), 32'(vecs[i].exp_rdy));
            after_edge();
            check($sformatf("v%0d_w_en", i), 32'(rf_w_en), 32'(vecs[i].exp_en));
            check($sformatf("v%0d_w_sel", i), 32'(rf_w_sel), 32'(vecs[i].exp_sel));
            check($sformatf("v%0d_w_data", i), rf_w_data, vecs[i].exp_data);
        end

        // starvation: debug refused 8 cycles, granted on the 9th
        @(negedge clk);
        drive_idle();
        lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h66;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
        dbg_valid = 1'b1; dbg_rd = 5'd7; dbg_data = 32'hDEAD;
        grant_cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            #1;
            if (dbg_ready) begin
                grant_cyc = c;
                break;
            end
            @(negedge clk);
        end
        check("starve_grant_cycle", 32'(grant_cyc), 32'd9);
        check("starve_lsu_blocked", 32'(lsu_ready), 32'd0);
        after_edge();
        check("starve_w_en", 32'(rf_w_en), 32'd1);
        check("starve_w_sel", 32'(rf_w_sel), 32'd7);
        check("starve_w_data", rf_w_data, 32'hDEAD);
        @(negedge clk);
        dbg_data = 32'hBEEF;
        #1;
        check("starve_cnt_cleared", 32'({lsu_ready, alu_ready, dbg_ready}), 32'b100);
        after_edge();
        check("starve_after_sel", 32'(rf_w_sel), 32'd6);

        // x0 write: handshake completes, no write enable
        @(negedge clk);
        drive_idle();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h99;
        #1;
        check("x0_alu_ready", 32'(alu_ready), 32'd1);
        after_edge();
        check("x0_w_en", 32'(rf_w_en), 32'd0);

        // in-flight hazard on rs2
        @(negedge clk);
        drive_idle();
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h12;
        chk_rs2 = 5'd12;
        #1;
        check("rs2_hazard_before", 32'(hazard), 32'd0);
        after_edge();
        check("rs2_hazard_inflight", 32'(hazard), 32'd1);
        @(negedge clk);
        alu_valid = 1'b0;
        after_edge();
        check("rs2_hazard_after", 32'(hazard), 32'd0);

        // asynchronous reset mid-transfer
        @(negedge clk);
        drive_idle();
        issue_valid = 1'b1; issue_rd = 5'd5;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h2222;
        after_edge();
        check("pre_reset_w_en", 32'(rf_w_en), 32'd1);
`ifdef REGFILE_WB_SCOREBOARD_EN
        check("pre_reset_busy5", busy, 32'h0000_0020);
`endif
        @(negedge clk);
        issue_valid = 1'b0;
        alu_data = 32'h3333;
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_w_en", 32'(rf_w_en), 32'd0);
        check("midreset_w_sel", 32'(rf_w_sel), 32'd0);
        check("midreset_w_data", rf_w_data, 32'd0);
        check("midreset_busy", busy, 32'd0);
        check("midreset_alu_ready", 32'(alu_ready), 32'd1);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        after_edge();
        check("postreset_w_en", 32'(rf_w_en), 32'd0);
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1234;
        after_edge();
        check("postreset_w_en2", 32'(rf_w_en), 32'd1);
        check("postreset_w_sel", 32'(rf_w_sel), 32'd3);
        check("postreset_w_data", rf_w_data, 32'h1234);
        @(negedge clk);
        drive_idle();
        after_edge();

`ifdef REGFILE_WB_SCOREBOARD_EN
        // scoreboard: set, hazard, re-issue blocked, clear via LSU
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd10;
        #1;
        check("sb_issue_ready", 32'(issue_ready), 32'd1);
        after_edge();
        check("sb_busy10_set", busy, 32'h0000_0400);
        @(negedge clk);
        chk_rs1 = 5'd10;
        #1;
        check("sb_reissue_ready", 32'(issue_ready), 32'd0);
        check("sb_hazard_busy", 32'(hazard), 32'd1);
        @(negedge clk);
        issue_valid = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'h55;
        #1;
        check("sb_lsu_ready", 32'(lsu_ready), 32'd1);
        after_edge();
        check("sb_busy10_clear", busy, 32'd0);
        check("sb_hazard_inflight", 32'(hazard), 32'd1);
        check("sb_w_data", rf_w_data, 32'h55);
        @(negedge clk);
        lsu_valid = 1'b0;
        after_edge();
        check("sb_hazard_gone", 32'(hazard), 32'd0);

        // same-edge set and clear of x9: set wins
        @(negedge clk);
        drive_idle();
        issue_valid = 1'b1; issue_rd = 5'd9;
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h9;
        #1;
        check("same_edge_issue_ready", 32'(issue_ready), 32'd1);
        after_edge();
        check("same_edge_busy9", busy, 32'h0000_0200);
        @(negedge clk);
        issue_valid = 1'b0;
        after_edge();
        check("busy9_cleared", busy, 32'd0);
        @(negedge clk);
        drive_idle();
`else
        // no scoreboard: issues ignored, hazard only from in-flight writes
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd10;
        chk_rs1 = 5'd10;
        #1;
        check("nosb_issue_ready", 32'(issue_ready), 32'd1);
        after_edge();
        check("nosb_busy", busy, 32'd0);
        check("nosb_hazard_idle", 32'(hazard), 32'd0);
        check("nosb_reissue_ready", 32'(issue_ready), 32'd1);
        @(negedge clk);
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h10;
        after_edge();
        check("nosb_hazard_inflight", 32'(hazard), 32'd1);
        @(negedge clk);
        alu_valid = 1'b0;
        after_edge();
        check("nosb_hazard_gone", 32'(hazard), 32'd0);
`endif

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
